// File: rtl/chan_512_swat_le_ctrl_if.sv
// Register-side and table-side signals of the SWAT_LE consumer.
// The master drives the software register; the slave drives the channel table port and counters.
interface chan_512_swat_le_ctrl_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int DROP_W = 8
);
   logic [31:0]       sw_reg;
   logic              tbl_we;
   logic [ADDR_W-1:0] tbl_addr;
   logic [DATA_W-1:0] tbl_data;
   logic              busy;
   logic [15:0]       wr_count;
   logic [DROP_W-1:0] drop_count;

   modport master (
      output sw_reg,
      input  tbl_we, tbl_addr, tbl_data, busy, wr_count, drop_count
   );

   modport slave (
      input  sw_reg,
      output tbl_we, tbl_addr, tbl_data, busy, wr_count, drop_count
   );
endinterface

// File: rtl/chan_512_swat_le_ctrl.sv
// Turns SWAT_LE register bit toggles into single channel-table writes or a full-table clear sweep,
// and keeps write / dropped-request counters for software readback.
module chan_512_swat_le_ctrl #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int DROP_W = 8
) (
   input  logic                     user_clk,
   input  logic                     user_rst_n,
   chan_512_swat_le_ctrl_if.slave   bus
);

   localparam int FLD_W = ADDR_W + DATA_W;

   typedef enum logic {IDLE, CLEAR} state_t;

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
   endfunction

   state_t              state, state_nxt;
   logic                le_p1, le_p2, clr_p1, clr_p2;
   logic [FLD_W-1:0]    fld_p1;
   logic [1:0]          arm_q;
   logic                armed, le_rise, clr_rise;

   logic                we_q, we_nxt;
   logic [ADDR_W-1:0]   addr_q, addr_nxt;
   logic [DATA_W-1:0]   data_q, data_nxt;
   logic                busy_q, busy_nxt;
   logic [15:0]         wr_q, wr_nxt;
   logic [DROP_W-1:0]   drop_q, drop_nxt;

   // Register bits between the field section and the two command bits carry no meaning here.
   logic unused_sw_bits;
   assign unused_sw_bits = ^bus.sw_reg[29:FLD_W];

   // p1/p2: two-deep sample of the register; fields travel with the p1 sample that carries the edge.
   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         le_p1  <= 1'b0;
         le_p2  <= 1'b0;
         clr_p1 <= 1'b0;
         clr_p2 <= 1'b0;
         fld_p1 <= '0;
         arm_q  <= 2'd0;
      end else begin
         le_p1  <= bus.sw_reg[31];
         clr_p1 <= bus.sw_reg[30];
         fld_p1 <= bus.sw_reg[FLD_W-1:0];
         le_p2  <= le_p1;
         clr_p2 <= clr_p1;
         if (!arm_q[1])
            arm_q <= arm_q + 2'd1;
      end
   end

   // Edges stay masked until the sample pipe holds two post-reset values.
   assign armed    = arm_q[1];
   assign le_rise  = armed & le_p1 & ~le_p2;
   assign clr_rise = armed & clr_p1 & ~clr_p2;

   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         state  <= IDLE;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         busy_q <= 1'b0;
         wr_q   <= '0;
         drop_q <= '0;
      end else begin
         state  <= state_nxt;
         we_q   <= we_nxt;
         addr_q <= addr_nxt;
         data_q <= data_nxt;
         busy_q <= busy_nxt;
         wr_q   <= wr_nxt;
         drop_q <= drop_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      we_nxt    = 1'b0;
      addr_nxt  = addr_q;
      data_nxt  = data_q;
      busy_nxt  = 1'b0;
      wr_nxt    = wr_q;
      drop_nxt  = drop_q;
      case (state)
         IDLE: begin
            if (clr_rise) begin
               // A clear arriving with an LE edge wins; the LE request is lost.
               state_nxt = CLEAR;
               we_nxt    = 1'b1;
               busy_nxt  = 1'b1;
               addr_nxt  = '0;
               data_nxt  = '0;
               if (le_rise)
                  drop_nxt = sat_inc(drop_q);
            end else if (le_rise) begin
               we_nxt   = 1'b1;
               addr_nxt = fld_p1[ADDR_W-1:0];
               data_nxt = fld_p1[FLD_W-1:ADDR_W];
               wr_nxt   = wr_q + 16'd1;
            end
         end
         CLEAR: begin
            if (le_rise)
               drop_nxt = sat_inc(drop_q);
            if (addr_q == {ADDR_W{1'b1}}) begin
               state_nxt = IDLE;
            end else begin
               we_nxt   = 1'b1;
               busy_nxt = 1'b1;
               addr_nxt = addr_q + ADDR_W'(1);
               data_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.tbl_we     = we_q;
   assign bus.tbl_addr   = addr_q;
   assign bus.tbl_data   = data_q;
   assign bus.busy       = busy_q;
   assign bus.wr_count   = wr_q;
   assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_chan_512_swat_le_ctrl.sv
// Scoreboard bench for the SWAT_LE consumer: directed register toggles push expected table writes,
// a negedge monitor pops and compares every strobe the block presents.
module tb_chan_512_swat_le_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   chan_512_swat_le_ctrl_if #(.ADDR_W(9), .DATA_W(16), .DROP_W(8)) bus ();

   chan_512_swat_le_ctrl #(.ADDR_W(9), .DATA_W(16), .DROP_W(8)) dut (
      .user_clk   (clk),
      .user_rst_n (rst_n),
      .bus        (bus)
   );

   typedef struct {
      logic [8:0]  addr;
      logic [15:0] data;
      logic        busy;
   } exp_t;

   exp_t exp_q[$];
   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] LE_BIT  = 32'h8000_0000;
   localparam logic [31:0] CLR_BIT = 32'h4000_0000;

   function automatic logic [31:0] mk(input bit le, input bit clr, input logic [8:0] a,
                                      input logic [15:0] d);
      return {le, clr, 5'b0, d, a};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_wr(input logic [8:0] a, input logic [15:0] d);
      exp_t e;
      e.addr = a; e.data = d; e.busy = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic push_clear();
      exp_t e;
      for (int i = 0; i < 512; i++) begin
         e.addr = 9'(i); e.data = 16'h0; e.busy = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   // Raises CLR, expects a full sweep, and returns one cycle after busy should have risen.
   task automatic start_clear();
      bus.sw_reg = CLR_BIT;
      push_clear();
      tick(1);
      bus.sw_reg = 32'h0;
      tick(1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 700) begin
         tick(1);
         n++;
      end
      if (bus.busy) chk("idle_timeout", {31'b0, bus.busy}, 32'h0);
   endtask

   // Monitor: every strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (bus.tbl_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual addr=0x%0h data=0x%0h expected=no strobe",
                     bus.tbl_addr, bus.tbl_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("strobe_addr", {23'b0, bus.tbl_addr}, {23'b0, e.addr});
            chk("strobe_data", {16'b0, bus.tbl_data}, {16'b0, e.data});
            chk("strobe_busy", {31'b0, bus.busy}, {31'b0, e.busy});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int busy_cycles;
      int n;

      // Reset with LE already high; nothing may fire after release.
      rst_n = 1'b0;
      bus.sw_reg = LE_BIT;
      tick(3);
      chk("rst_we",   {31'b0, bus.tbl_we}, 32'h0);
      chk("rst_addr", {23'b0, bus.tbl_addr}, 32'h0);
      chk("rst_data", {16'b0, bus.tbl_data}, 32'h0);
      chk("rst_busy", {31'b0, bus.busy}, 32'h0);
      chk("rst_wr",   {16'b0, bus.wr_count}, 32'h0);
      chk("rst_drop", {24'b0, bus.drop_count}, 32'h0);
      rst_n = 1'b1;
      tick(10);
      chk("held_le_wr", {16'b0, bus.wr_count}, 32'h0);

      bus.sw_reg = 32'h0;
      tick(2);
      bus.sw_reg = mk(1'b1, 1'b0, 9'd5, 16'h1234);
      push_wr(9'd5, 16'h1234);
      tick(1);
      chk("le_lat_k",   {31'b0, bus.tbl_we}, 32'h0);
      tick(1);
      chk("le_lat_k1",  {31'b0, bus.tbl_we}, 32'h1);
      chk("le_wr_cnt1", {16'b0, bus.wr_count}, 32'h1);
      tick(1);
      chk("le_lat_k2",  {31'b0, bus.tbl_we}, 32'h0);
      bus.sw_reg = 32'h0;
      tick(1);

      // Back-to-back writes at minimum spacing; middle one carries junk in unused bits.
      bus.sw_reg = mk(1'b1, 1'b0, 9'd0, 16'hA5A5);
      push_wr(9'd0, 16'hA5A5);
      tick(1); bus.sw_reg = 32'h0; tick(1);
      bus.sw_reg = mk(1'b1, 1'b0, 9'd255, 16'h0001) | 32'h3E00_0000;
      push_wr(9'd255, 16'h0001);
      tick(1); bus.sw_reg = 32'h0; tick(1);
      bus.sw_reg = mk(1'b1, 1'b0, 9'd511, 16'hFFFF);
      push_wr(9'd511, 16'hFFFF);
      tick(1); bus.sw_reg = 32'h0; tick(3);
      chk("b2b_wr_cnt", {16'b0, bus.wr_count}, 32'h4);
      chk("b2b_drained", exp_q.size(), 32'h0);

      // Full clear: busy high for exactly 512 cycles.
      bus.sw_reg = CLR_BIT;
      push_clear();
      tick(1);
      chk("clr_lat_k", {31'b0, bus.busy}, 32'h0);
      bus.sw_reg = 32'h0;
      busy_cycles = 0;
      for (int i = 0; i < 512; i++) begin
         tick(1);
         if (bus.busy === 1'b1) busy_cycles++;
      end
      chk("clr_busy_cycles", busy_cycles, 32'd512);
      tick(1);
      chk("clr_busy_fall", {31'b0, bus.busy}, 32'h0);
      chk("clr_drained", exp_q.size(), 32'h0);

      // LE and a second CLR during a sweep, then LE+CLR together.
      start_clear();
      tick(100);
      bus.sw_reg = mk(1'b1, 1'b0, 9'd7, 16'hBEEF);
      tick(1); bus.sw_reg = 32'h0; tick(2);
      bus.sw_reg = CLR_BIT;
      tick(1); bus.sw_reg = 32'h0;
      wait_idle();
      tick(2);
      bus.sw_reg = mk(1'b1, 1'b1, 9'd9, 16'h5555);
      push_clear();
      tick(1); bus.sw_reg = 32'h0; tick(1);
      wait_idle();
      tick(2);
      chk("drop_two", {24'b0, bus.drop_count}, 32'h2);
      chk("drop_wr_cnt", {16'b0, bus.wr_count}, 32'h4);

      // 300 LE pulses across two sweeps: counter saturates.
      for (int c = 0; c < 2; c++) begin
         start_clear();
         repeat (150) begin
            bus.sw_reg = mk(1'b1, 1'b0, 9'd3, 16'h0F0F);
            tick(1); bus.sw_reg = 32'h0; tick(1);
         end
         wait_idle();
         tick(2);
         if (c == 0) chk("drop_mid", {24'b0, bus.drop_count}, 32'd152);
      end
      chk("drop_sat", {24'b0, bus.drop_count}, 32'd255);

      // Reset in the middle of a sweep, then a fresh sweep from address 0.
      start_clear();
      n = 0;
      while (bus.tbl_addr !== 9'd200 && n < 600) begin
         tick(1);
         n++;
      end
      chk("rst_mid_reached", {23'b0, bus.tbl_addr}, 32'd200);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      tick(1);
      chk("rstm_we",   {31'b0, bus.tbl_we}, 32'h0);
      chk("rstm_busy", {31'b0, bus.busy}, 32'h0);
      chk("rstm_addr", {23'b0, bus.tbl_addr}, 32'h0);
      chk("rstm_wr",   {16'b0, bus.wr_count}, 32'h0);
      chk("rstm_drop", {24'b0, bus.drop_count}, 32'h0);
      tick(1);
      rst_n = 1'b1;
      tick(3);
      start_clear();
      wait_idle();
      tick(2);
      chk("final_drained", exp_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
